pcileech_iobridge_peer: RTL and testbench
=========================================

Name: pcileech_iobridge_peer

Overview:
Bridge-side peer of the FPGA IO bridge bus. It drives the 41-bit host-to-FPGA word bus with its forwarded strobe clock, and receives the 67-bit FPGA-to-host bus into a buffer. It provides the programmable-full backpressure and the Thunderbolt connect indication consumed by the PCIe core's power-switch logic. It is used as the bridge-chip model in system simulation and as the peer logic on bridge-capable boards.

Parameters:
DI_DEPTH, 64, RX FIFO depth in 64-bit words; must be a power of two, at least 16.
DI_PF_MARGIN, 8, bus_di_prog_full asserts when occupancy is at least DI_DEPTH-DI_PF_MARGIN.
CONNECT_DELAY, 1000, clk cycles spent in CONNECTING before tb_connect asserts; at least 1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
host_enable  in  1  level; 1 requests link up
host_tx_data  in  32  host-to-FPGA payload
host_tx_valid  in  1  tx word valid
host_tx_ready  out  1  tx word accepted when valid&ready
host_rx_data  out  64  FPGA-to-host payload
host_rx_type  out  2  word type field from bus_di[65:64]
host_rx_valid  out  1  rx FIFO non-empty
host_rx_ready  in  1  pop rx head when valid&ready
bus_do  out  41  [40]=valid, [39:32]=tag, [31:0]=data
bus_do_clk  out  1  forwarded strobe; receiver samples bus_do on its rising edge
bus_di  in  67  [66]=valid, [65:64]=type, [63:0]=data; sampled every clk
bus_di_prog_full  out  1  backpressure to the FPGA writer
tb_connect  out  1  link-connected indication
status_overflow  out  1  sticky; an rx word was dropped
rx_count  out  $clog2(DI_DEPTH)+1  rx FIFO occupancy

Behaviour:
- Reset values: all outputs 0; state=DISCONNECTED; phase ph=0; tag=0; FIFO empty.
- Link FSM:
  - DISCONNECTED -> CONNECTING when host_enable=1. The delay counter loads 0.
  - CONNECTING: the counter increments each cycle. Go to CONNECTED when counter==CONNECT_DELAY-1.
  - CONNECTED: tb_connect=1, registered, so it rises in the first CONNECTED cycle.
  - In any state, host_enable=0 -> DISCONNECTED next cycle. Also: tag<=0, rx FIFO flushed, status_overflow cleared, bus_do<=0.
- Strobe:
  - ph toggles every cycle from reset release, in all states; bus_do_clk=ph (registered).
  - bus_do changes only on the edge where ph goes 1->0.
  - Receiver sampling at the 0->1 edge sees data that has been stable for one full cycle.
- TX:
  - host_tx_ready = (state==CONNECTED) & (ph==1), combinational from registered terms.
  - In a cycle with ph==1:
    - If valid&ready: next cycle bus_do={1,tag,host_tx_data}, and tag increments modulo 256 (0xFF wraps to 0x00).
    - Otherwise: next cycle bus_do[40]=0, and [39:0] holds its previous value.
  - Each word is held 2 cycles. Peak rate is 1 word per 2 clk.
- RX FIFO:
  - Write when bus_di[66]=1 and state!=DISCONNECTED. Words arriving in DISCONNECTED are ignored, with no overflow.
  - Write is accepted if rx_count<DI_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and status_overflow<=1 (sticky).
  - Pop on host_rx_valid&host_rx_ready.
  - host_rx_data/type show the head word with no read latency (first-word-fall-through).
  - Simultaneous push and pop leaves rx_count unchanged. Pointers wrap modulo DI_DEPTH.
- bus_di_prog_full is registered: it equals (rx_count >= DI_DEPTH-DI_PF_MARGIN) evaluated on the post-update count, so it is valid the cycle after the count changes.
- The FIFO tolerates the 1-cycle prog_full lag plus DI_PF_MARGIN words in flight without loss.
- rst mid-operation clears everything within one cycle. A word in flight on bus_do is abandoned (valid goes 0).

Test Plan:
1. Reset, host_enable=1 at cycle 0 with CONNECT_DELAY=4 -> tb_connect=0 through cycle 4, then 1 from cycle 5. host_tx_ready=0 before tb_connect.
2. Connected; push 0xDEADBEEF then 0x12345678 back to back -> bus_do={1,0x00,DEADBEEF}, then {1,0x01,12345678}. Each is held 2 cycles and changes only when bus_do_clk falls. Valid drops when no further word is pushed.
3. Push 258 words -> tags run 0x00..0xFF, 0x00, 0x01. Throughput is exactly 1 word per 2 clk.
4. DI_DEPTH=16, DI_PF_MARGIN=4; drive 14 valid bus_di words with host_rx_ready=0 -> prog_full=1 the cycle after the 12th write. All 14 pop in order with correct type/data.
5. Fill to 16, then drive a 17th word with no pop -> dropped, status_overflow=1, rx_count=16. Repeat with a simultaneous pop -> accepted, count stays 16.
6. Mid-transfer, host_enable=0 -> next cycle: tb_connect=0, rx_count=0, overflow cleared, bus_do=0, tag restarts at 0x00 on reconnect.

Source files
------------

// File: rtl/pcileech_iobridge_peer_if.sv
// Signal bundle between the IO bridge peer (slave) and its host/FPGA-side environment (master).
interface pcileech_iobridge_peer_if #(
  parameter int DI_DEPTH = 64
);
  localparam int CW = $clog2(DI_DEPTH) + 1;

  logic          host_enable;
  logic [31:0]   host_tx_data;
  logic          host_tx_valid;
  logic          host_tx_ready;
  logic [63:0]   host_rx_data;
  logic [1:0]    host_rx_type;
  logic          host_rx_valid;
  logic          host_rx_ready;
  logic [40:0]   bus_do;
  logic          bus_do_clk;
  logic [66:0]   bus_di;
  logic          bus_di_prog_full;
  logic          tb_connect;
  logic          status_overflow;
  logic [CW-1:0] rx_count;

  modport master (
    output host_enable, host_tx_data, host_tx_valid, host_rx_ready, bus_di,
    input  host_tx_ready, host_rx_data, host_rx_type, host_rx_valid,
           bus_do, bus_do_clk, bus_di_prog_full, tb_connect, status_overflow, rx_count
  );

  modport slave (
    input  host_enable, host_tx_data, host_tx_valid, host_rx_ready, bus_di,
    output host_tx_ready, host_rx_data, host_rx_type, host_rx_valid,
           bus_do, bus_do_clk, bus_di_prog_full, tb_connect, status_overflow, rx_count
  );
endinterface

// File: rtl/pcileech_iobridge_peer.sv
// Bridge-side peer of the FPGA IO bridge: strobed 41-bit TX word bus, FWFT RX buffer
// with programmable-full backpressure, and a delayed Thunderbolt connect indication.
//   state         | meaning
//   ST_DISC       | link down, rx input ignored
//   ST_CONNECTING | waiting CONNECT_DELAY cycles before reporting connect
//   ST_CONNECTED  | tb_connect high, tx words accepted on ph==1
module pcileech_iobridge_peer #(
  parameter int DI_DEPTH      = 64,
  parameter int DI_PF_MARGIN  = 8,
  parameter int CONNECT_DELAY = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  pcileech_iobridge_peer_if.slave io
);
  localparam int PW    = $clog2(DI_DEPTH);
  localparam int CW    = PW + 1;
  localparam int CNT_W = (CONNECT_DELAY > 1) ? $clog2(CONNECT_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONNECT_DELAY - 1);
  localparam logic [CW-1:0]    RX_FULL  = CW'(DI_DEPTH);
  localparam logic [CW-1:0]    RX_PF    = CW'(DI_DEPTH - DI_PF_MARGIN);

  localparam logic [1:0] ST_DISC       = 2'd0;
  localparam logic [1:0] ST_CONNECTING = 2'd1;
  localparam logic [1:0] ST_CONNECTED  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] dly_cnt;
  logic             ph;
  logic             tb_connect_q;
  logic [40:0]      bus_do_q;
  logic [7:0]       tag;

  logic [65:0]      mem [DI_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             overflow_q;
  logic             prog_full_q;

  logic             tx_ready;
  logic             tx_fire;
  logic             rx_valid;
  logic             rx_pop;
  logic             di_valid;
  logic             rx_push;
  logic             rx_drop;

  assign tx_ready = (state == ST_CONNECTED) && ph;
  assign tx_fire  = tx_ready && io.host_tx_valid;
  assign rx_valid = (count != '0);
  assign rx_pop   = rx_valid && io.host_rx_ready;
  assign di_valid = io.bus_di[66] && (state != ST_DISC);
  // A full buffer still takes a word when the head leaves in the same cycle.
  assign rx_push  = di_valid && ((count != RX_FULL) || rx_pop);
  assign rx_drop  = di_valid && !rx_push;

  always_comb begin
    state_next = state;
    if (!io.host_enable) begin
      state_next = ST_DISC;
    end else begin
      case (state)
        ST_DISC:       state_next = ST_CONNECTING;
        ST_CONNECTING: if (dly_cnt == CNT_LAST) state_next = ST_CONNECTED;
        ST_CONNECTED:  state_next = ST_CONNECTED;
        default:       state_next = ST_DISC;
      endcase
    end
  end

  always_comb begin
    count_next = count;
    if (!io.host_enable)
      count_next = '0;
    else if (rx_push && !rx_pop)
      count_next = count + CW'(1);
    else if (!rx_push && rx_pop)
      count_next = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_DISC;
      dly_cnt      <= '0;
      ph           <= 1'b0;
      tb_connect_q <= 1'b0;
      bus_do_q     <= '0;
      tag          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_q   <= 1'b0;
      prog_full_q  <= 1'b0;
    end else begin
      state        <= state_next;
      tb_connect_q <= (state_next == ST_CONNECTED);
      ph           <= ~ph;
      dly_cnt      <= (state == ST_CONNECTING) ? dly_cnt + CNT_W'(1) : '0;
      count        <= count_next;
      prog_full_q  <= (count_next >= RX_PF);
      if (!io.host_enable) begin
        tag        <= '0;
        bus_do_q   <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        overflow_q <= 1'b0;
      end else begin
        // bus_do only moves on the falling strobe so the receiver sees a full stable cycle.
        if (ph) begin
          if (tx_fire) begin
            bus_do_q <= {1'b1, tag, io.host_tx_data};
            tag      <= tag + 8'd1;
          end else begin
            bus_do_q[40] <= 1'b0;
          end
        end
        if (rx_push) wr_ptr <= wr_ptr + PW'(1);
        if (rx_pop)  rd_ptr <= rd_ptr + PW'(1);
        if (rx_drop) overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push && io.host_enable && !rst)
      mem[wr_ptr] <= io.bus_di[65:0];
  end

  assign io.host_tx_ready    = tx_ready;
  assign io.host_rx_valid    = rx_valid;
  assign io.host_rx_data     = rx_valid ? mem[rd_ptr][63:0]  : 64'd0;
  assign io.host_rx_type     = rx_valid ? mem[rd_ptr][65:64] : 2'd0;
  assign io.bus_do           = bus_do_q;
  assign io.bus_do_clk       = ph;
  assign io.bus_di_prog_full = prog_full_q;
  assign io.tb_connect       = tb_connect_q;
  assign io.status_overflow  = overflow_q;
  assign io.rx_count         = count;
endmodule

// File: tb/tb_pcileech_iobridge_peer.sv
// Self-checking bench for pcileech_iobridge_peer: connect timing, strobed TX, tag wrap,
// RX buffering/backpressure/overflow, disconnect flush and mid-operation reset.
module tb_pcileech_iobridge_peer;
  localparam int DEPTH  = 16;
  localparam int MARGIN = 4;
  localparam int DELAY  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail  = 0;
  logic [65:0] rx_model [$];
  logic [7:0]  m_tag = 8'd0;

  pcileech_iobridge_peer_if #(.DI_DEPTH(DEPTH)) io ();

  pcileech_iobridge_peer #(
    .DI_DEPTH(DEPTH), .DI_PF_MARGIN(MARGIN), .CONNECT_DELAY(DELAY)
  ) dut (
    .clk(clk), .rst(rst), .io(io.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int g = 0;
    while (io.host_tx_ready !== 1'b1 && g < 4) begin step(); g++; end
    if (io.host_tx_ready !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL wait_ready: host_tx_ready=%b required 1 within 4 cycles", io.host_tx_ready);
    end
  endtask

  task automatic reconnect();
    int g = 0;
    io.host_enable = 1'b0;
    step();
    io.host_enable = 1'b1;
    while (io.tb_connect !== 1'b1 && g < DELAY + 4) begin step(); g++; end
    if (io.tb_connect !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL reconnect: tb_connect=%b required 1 within %0d cycles", io.tb_connect, DELAY + 4);
    end
    m_tag = 8'd0;
    rx_model.delete();
  endtask

  task automatic test_reset();
    logic exp_conn, exp_ph;
    io.host_enable = 1'b0; io.host_tx_valid = 1'b0; io.host_tx_data = '0;
    io.host_rx_ready = 1'b0; io.bus_di = '0;
    rst = 1'b1;
    repeat (3) step();
    n_tests++;
    if ({io.bus_do, io.bus_do_clk, io.tb_connect, io.host_tx_ready, io.host_rx_valid,
         io.host_rx_data, io.host_rx_type, io.bus_di_prog_full, io.status_overflow,
         io.rx_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: bus_do=%h clk=%b conn=%b rdy=%b rxv=%b cnt=%0d pf=%b ovf=%b required all 0",
               io.bus_do, io.bus_do_clk, io.tb_connect, io.host_tx_ready, io.host_rx_valid,
               io.rx_count, io.bus_di_prog_full, io.status_overflow);
    end
    rst = 1'b0;
    io.host_enable = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_conn = (k >= DELAY + 1);
      exp_ph   = (k % 2 == 1);
      n_tests++;
      if ({io.tb_connect, io.bus_do_clk, io.host_tx_ready} !== {exp_conn, exp_ph, exp_conn & exp_ph}) begin
        n_fail++;
        $display("FAIL connect_seq k=%0d: conn/strobe/rdy=%b%b%b required %b%b%b", k,
                 io.tb_connect, io.bus_do_clk, io.host_tx_ready, exp_conn, exp_ph, exp_conn & exp_ph);
      end
    end
  endtask

  task automatic test_tx_basic();
    logic [40:0] exp_a, exp_b;
    wait_ready();
    exp_a = {1'b1, m_tag, 32'hDEADBEEF}; m_tag++;
    exp_b = {1'b1, m_tag, 32'h12345678}; m_tag++;
    io.host_tx_data = 32'hDEADBEEF; io.host_tx_valid = 1'b1;
    step();
    io.host_tx_data = 32'h12345678;
    n_tests++;
    if ({io.bus_do, io.bus_do_clk} !== {exp_a, 1'b0}) begin
      n_fail++; $display("FAIL tx_a_first: bus_do=%h clk=%b required %h 0", io.bus_do, io.bus_do_clk, exp_a);
    end
    step();
    n_tests++;
    if ({io.bus_do, io.bus_do_clk} !== {exp_a, 1'b1}) begin
      n_fail++; $display("FAIL tx_a_hold: bus_do=%h clk=%b required %h 1", io.bus_do, io.bus_do_clk, exp_a);
    end
    step();
    io.host_tx_valid = 1'b0;
    n_tests++;
    if ({io.bus_do, io.bus_do_clk} !== {exp_b, 1'b0}) begin
      n_fail++; $display("FAIL tx_b_first: bus_do=%h clk=%b required %h 0", io.bus_do, io.bus_do_clk, exp_b);
    end
    step();
    n_tests++;
    if ({io.bus_do, io.bus_do_clk} !== {exp_b, 1'b1}) begin
      n_fail++; $display("FAIL tx_b_hold: bus_do=%h clk=%b required %h 1", io.bus_do, io.bus_do_clk, exp_b);
    end
    step();
    n_tests++;
    if (io.bus_do !== {1'b0, exp_b[39:0]}) begin
      n_fail++; $display("FAIL tx_idle: bus_do=%h required %h", io.bus_do, {1'b0, exp_b[39:0]});
    end
  endtask

  task automatic test_tag_wrap();
    logic [31:0] d;
    logic [40:0] exp;
    reconnect();
    wait_ready();
    io.host_tx_valid = 1'b1;
    for (int i = 0; i < 258; i++) begin
      d = $urandom;
      io.host_tx_data = d;
      exp = {1'b1, m_tag, d}; m_tag++;
      step();
      n_tests++;
      if ({io.bus_do, io.bus_do_clk} !== {exp, 1'b0}) begin
        n_fail++; $display("FAIL tag_wrap_word %0d: bus_do=%h clk=%b required %h 0", i, io.bus_do, io.bus_do_clk, exp);
      end
      step();
      n_tests++;
      if ({io.bus_do, io.bus_do_clk, io.host_tx_ready} !== {exp, 1'b1, 1'b1}) begin
        n_fail++; $display("FAIL tag_wrap_hold %0d: bus_do=%h clk=%b rdy=%b required %h 1 1", i,
                           io.bus_do, io.bus_do_clk, io.host_tx_ready, exp);
      end
    end
    io.host_tx_valid = 1'b0;
    step();
    n_tests++;
    if (io.bus_do[40] !== 1'b0) begin
      n_fail++; $display("FAIL tag_wrap_idle: valid=%b required 0", io.bus_do[40]);
    end
  endtask

  task automatic test_prog_full();
    logic [1:0]  t;
    logic [63:0] d;
    io.host_rx_ready = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      t = 2'($urandom_range(0, 3)); d = {$urandom, $urandom};
      io.bus_di = {1'b1, t, d};
      rx_model.push_back({t, d});
      step();
      n_tests++;
      if ({io.rx_count, io.bus_di_prog_full} !== {5'(k), (k >= DEPTH - MARGIN)}) begin
        n_fail++; $display("FAIL fill_pf k=%0d: count=%0d pf=%b required %0d %b", k,
                           io.rx_count, io.bus_di_prog_full, k, (k >= DEPTH - MARGIN));
      end
    end
    io.bus_di = '0;
    io.host_rx_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      n_tests++;
      if ({io.host_rx_valid, io.host_rx_type, io.host_rx_data} !== {1'b1, rx_model[0]}) begin
        n_fail++; $display("FAIL pop_order %0d: v=%b type=%0d data=%h required 1 %0d %h", i,
                           io.host_rx_valid, io.host_rx_type, io.host_rx_data, rx_model[0][65:64], rx_model[0][63:0]);
      end
      void'(rx_model.pop_front());
      step();
      n_tests++;
      if ({io.rx_count, io.bus_di_prog_full} !== {5'(rx_model.size()), (rx_model.size() >= DEPTH - MARGIN)}) begin
        n_fail++; $display("FAIL drain_pf %0d: count=%0d pf=%b required %0d", i,
                           io.rx_count, io.bus_di_prog_full, rx_model.size());
      end
    end
    io.host_rx_ready = 1'b0;
    n_tests++;
    if (io.host_rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL empty_valid: host_rx_valid=%b required 0", io.host_rx_valid);
    end
  endtask

  task automatic test_overflow();
    logic [1:0]  t;
    logic [63:0] d;
    io.host_rx_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      t = 2'($urandom_range(0, 3)); d = {$urandom, $urandom};
      io.bus_di = {1'b1, t, d};
      rx_model.push_back({t, d});
      step();
    end
    n_tests++;
    if ({io.rx_count, io.bus_di_prog_full, io.status_overflow} !== {5'(DEPTH), 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL full_state: count=%0d pf=%b ovf=%b required %0d 1 0",
                         io.rx_count, io.bus_di_prog_full, io.status_overflow, DEPTH);
    end
    io.bus_di = {1'b1, 2'd3, 64'hBAD0_BAD0_BAD0_BAD0};
    step();
    n_tests++;
    if ({io.rx_count, io.status_overflow} !== {5'(DEPTH), 1'b1}) begin
      n_fail++; $display("FAIL drop_word: count=%0d ovf=%b required %0d 1", io.rx_count, io.status_overflow, DEPTH);
    end
    t = 2'($urandom_range(0, 3)); d = {$urandom, $urandom};
    io.bus_di = {1'b1, t, d};
    io.host_rx_ready = 1'b1;
    void'(rx_model.pop_front());
    rx_model.push_back({t, d});
    step();
    io.bus_di = '0;
    n_tests++;
    if (io.rx_count !== 5'(DEPTH)) begin
      n_fail++; $display("FAIL push_pop_full: count=%0d required %0d", io.rx_count, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_tests++;
      if ({io.host_rx_valid, io.host_rx_type, io.host_rx_data} !== {1'b1, rx_model[0]}) begin
        n_fail++; $display("FAIL ovf_order %0d: v=%b type=%0d data=%h required 1 %0d %h", i,
                           io.host_rx_valid, io.host_rx_type, io.host_rx_data, rx_model[0][65:64], rx_model[0][63:0]);
      end
      void'(rx_model.pop_front());
      step();
    end
    io.host_rx_ready = 1'b0;
    n_tests++;
    if ({io.host_rx_valid, io.rx_count, io.status_overflow} !== {1'b0, 5'd0, 1'b1}) begin
      n_fail++; $display("FAIL ovf_sticky: v=%b count=%0d ovf=%b required 0 0 1",
                         io.host_rx_valid, io.rx_count, io.status_overflow);
    end
  endtask

  task automatic test_disconnect();
    logic [31:0] w;
    logic [40:0] exp;
    int g = 0;
    for (int k = 0; k <= DEPTH; k++) begin
      io.bus_di = {1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom};
      step();
    end
    io.bus_di = '0;
    wait_ready();
    w = $urandom;
    io.host_tx_data = w; io.host_tx_valid = 1'b1;
    exp = {1'b1, m_tag, w};
    step();
    io.host_tx_valid = 1'b0;
    n_tests++;
    if ({io.bus_do, io.rx_count, io.status_overflow} !== {exp, 5'(DEPTH), 1'b1}) begin
      n_fail++; $display("FAIL pre_disc: bus_do=%h count=%0d ovf=%b required %h %0d 1",
                         io.bus_do, io.rx_count, io.status_overflow, exp, DEPTH);
    end
    io.host_enable = 1'b0;
    step();
    n_tests++;
    if ({io.tb_connect, io.rx_count, io.host_rx_valid, io.status_overflow, io.bus_do, io.bus_di_prog_full} !== '0) begin
      n_fail++; $display("FAIL disc_flush: conn=%b count=%0d v=%b ovf=%b bus_do=%h pf=%b required all 0",
                         io.tb_connect, io.rx_count, io.host_rx_valid, io.status_overflow, io.bus_do, io.bus_di_prog_full);
    end
    io.host_enable = 1'b1;
    io.bus_di = {1'b1, 2'd1, 64'h0123_4567_89AB_CDEF};
    step();
    io.bus_di = '0;
    n_tests++;
    if ({io.rx_count, io.status_overflow} !== {5'd0, 1'b0}) begin
      n_fail++; $display("FAIL disc_ignore: count=%0d ovf=%b required 0 0", io.rx_count, io.status_overflow);
    end
    while (io.tb_connect !== 1'b1 && g < DELAY + 4) begin step(); g++; end
    m_tag = 8'd0;
    wait_ready();
    w = $urandom;
    io.host_tx_data = w; io.host_tx_valid = 1'b1;
    exp = {1'b1, m_tag, w}; m_tag++;
    step();
    io.host_tx_valid = 1'b0;
    n_tests++;
    if (io.bus_do !== exp) begin
      n_fail++; $display("FAIL tag_restart: bus_do=%h required %h", io.bus_do, exp);
    end
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 3; k++) begin
      io.bus_di = {1'b1, 2'd2, $urandom, $urandom};
      step();
    end
    io.bus_di = '0;
    wait_ready();
    io.host_tx_data = $urandom; io.host_tx_valid = 1'b1;
    step();
    io.host_tx_valid = 1'b0;
    rst = 1'b1;
    step();
    n_tests++;
    if ({io.bus_do, io.bus_do_clk, io.tb_connect, io.host_tx_ready, io.host_rx_valid,
         io.rx_count, io.bus_di_prog_full, io.status_overflow} !== '0) begin
      n_fail++; $display("FAIL mid_reset: bus_do=%h clk=%b conn=%b rdy=%b v=%b count=%0d pf=%b ovf=%b required all 0",
                         io.bus_do, io.bus_do_clk, io.tb_connect, io.host_tx_ready, io.host_rx_valid,
                         io.rx_count, io.bus_di_prog_full, io.status_overflow);
    end
    rst = 1'b0;
    io.host_enable = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tag_wrap();
    test_prog_full();
    test_overflow();
    test_disconnect();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
